// File: rtl/rob_multiport.sv
// Reorder buffer with N writeback channels, two bypassing operand lookups and
// in-order single-entry commit to register file, store path and branch predictor.
module rob_multiport #(
  parameter int DEPTH_W = 5,
  parameter int NUM_WB  = 3
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  output logic [DEPTH_W-1:0]        disp_tag,
  input  logic [2:0]                disp_type,
  input  logic                      disp_is_c,
  input  logic [4:0]                disp_rd,
  input  logic [31:0]               disp_pc,
  input  logic                      disp_pred_taken,
  input  logic [31:0]               disp_pred_target,
  input  logic                      disp_done,
  input  logic [31:0]               disp_value,
  input  logic [NUM_WB-1:0]         wb_valid,
  input  logic [NUM_WB*DEPTH_W-1:0] wb_tag,
  input  logic [NUM_WB*32-1:0]      wb_value,
  input  logic [NUM_WB*32-1:0]      wb_addr,
  input  logic [2*DEPTH_W-1:0]      qry_tag,
  output logic [1:0]                qry_ready,
  output logic [63:0]               qry_value,
  output logic                      commit_rf_valid,
  output logic [4:0]                commit_rd,
  output logic [31:0]               commit_value,
  output logic [DEPTH_W-1:0]        commit_tag,
  output logic                      commit_st_valid,
  output logic [1:0]                commit_st_size,
  output logic [31:0]               commit_st_addr,
  output logic [31:0]               commit_st_data,
  input  logic                      st_busy,
  output logic                      commit_br_valid,
  output logic [31:0]               commit_br_pc,
  output logic                      commit_br_taken,
  output logic                      flush_out,
  output logic [31:0]               flush_pc,
  output logic                      halt_out,
  output logic [DEPTH_W:0]          count_out
);
  localparam int DEPTH = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] CNT_FULL = (DEPTH_W+1)'(DEPTH);
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [2:0] TY_SW     = 3'd2;
  localparam logic [2:0] TY_REG    = 3'd3;
  localparam logic [2:0] TY_JALR   = 3'd4;
  localparam logic [2:0] TY_BRANCH = 3'd5;
  localparam logic [2:0] TY_EXIT   = 3'd6;

  logic [1:0]         state_reg [DEPTH];
  logic [2:0]         type_reg [DEPTH];
  logic               is_c_reg [DEPTH];
  logic [4:0]         rd_reg [DEPTH];
  logic [31:0]        pc_reg [DEPTH];
  logic               pred_taken_reg [DEPTH];
  logic [31:0]        pred_tgt_reg [DEPTH];
  logic [31:0]        value_reg [DEPTH];
  logic [31:0]        addr_reg [DEPTH];
  logic [DEPTH_W-1:0] head_reg, rear_reg;
  logic [DEPTH_W:0]   count_reg;

  logic [DEPTH-1:0]   wb_hit;
  logic [31:0]        wb_sel_value [DEPTH];
  logic [31:0]        wb_sel_addr [DEPTH];
  logic [2:0]         head_type;
  logic [31:0]        head_value, head_link;
  logic               head_is_store, head_ok, pop, mispredict, accept;

  assign disp_ready = (count_reg != CNT_FULL) && !flush_out;
  assign disp_tag   = rear_reg;
  assign count_out  = count_reg;

  // Per-entry writeback selection; the descending scan leaves the lowest channel in place.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wb_hit[i]       = 1'b0;
      wb_sel_value[i] = '0;
      wb_sel_addr[i]  = '0;
      for (int k = NUM_WB - 1; k >= 0; k--) begin
        if (wb_valid[k] && !flush_out && wb_tag[k*DEPTH_W +: DEPTH_W] == DEPTH_W'(i)) begin
          wb_hit[i]       = 1'b1;
          wb_sel_value[i] = wb_value[k*32 +: 32];
          wb_sel_addr[i]  = wb_addr[k*32 +: 32];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_qry
      logic [DEPTH_W-1:0] q_tag;
      logic               q_rdy;
      logic [31:0]        q_val;
      assign q_tag = qry_tag[gi*DEPTH_W +: DEPTH_W];
      always_comb begin
        q_rdy = 1'b0;
        q_val = '0;
        if (state_reg[q_tag] == ST_READY) begin
          q_rdy = 1'b1;
          q_val = value_reg[q_tag];
        end else if (wb_hit[q_tag]) begin
          q_rdy = 1'b1;
          q_val = wb_sel_value[q_tag];
        end
      end
      assign qry_ready[gi]          = q_rdy;
      assign qry_value[gi*32 +: 32] = q_val;
    end
  endgenerate

  assign head_type     = type_reg[head_reg];
  assign head_value    = value_reg[head_reg];
  assign head_link     = pc_reg[head_reg] + (is_c_reg[head_reg] ? 32'd2 : 32'd4);
  assign head_is_store = (head_type <= TY_SW);
  assign head_ok       = (count_reg != '0) && (state_reg[head_reg] == ST_READY) && !halt_out;
  assign pop           = rdy_in && head_ok && !(head_is_store && st_busy);
  assign mispredict    = pop && (((head_type == TY_JALR) && (head_value != pred_tgt_reg[head_reg])) ||
                                 ((head_type == TY_BRANCH) && (head_value[0] != pred_taken_reg[head_reg])));
  assign accept        = rdy_in && disp_valid && disp_ready && !mispredict;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_reg        <= '0;
      rear_reg        <= '0;
      count_reg       <= '0;
      commit_rf_valid <= 1'b0;
      commit_rd       <= '0;
      commit_value    <= '0;
      commit_tag      <= '0;
      commit_st_valid <= 1'b0;
      commit_st_size  <= '0;
      commit_st_addr  <= '0;
      commit_st_data  <= '0;
      commit_br_valid <= 1'b0;
      commit_br_pc    <= '0;
      commit_br_taken <= 1'b0;
      flush_out       <= 1'b0;
      flush_pc        <= '0;
      halt_out        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) state_reg[i] <= ST_EMPTY;
    end else if (rdy_in) begin
      commit_rf_valid <= 1'b0;
      commit_st_valid <= 1'b0;
      commit_br_valid <= 1'b0;
      flush_out       <= mispredict;
      if (pop) begin
        if (head_type == TY_REG || head_type == TY_JALR) begin
          commit_rf_valid <= 1'b1;
          commit_rd       <= rd_reg[head_reg];
          commit_value    <= (head_type == TY_JALR) ? head_link : head_value;
          commit_tag      <= head_reg;
        end
        if (head_is_store) begin
          commit_st_valid <= 1'b1;
          commit_st_size  <= head_type[1:0];
          commit_st_addr  <= addr_reg[head_reg];
          commit_st_data  <= head_value;
        end
        if (head_type == TY_BRANCH) begin
          commit_br_valid <= 1'b1;
          commit_br_pc    <= pc_reg[head_reg];
          commit_br_taken <= head_value[0];
        end
        if (head_type == TY_EXIT) halt_out <= 1'b1;
        if (mispredict) begin
          flush_pc <= (head_type == TY_JALR) ? head_value :
                      (head_value[0] ? pred_tgt_reg[head_reg] : head_link);
        end
      end
      if (mispredict) begin
        head_reg  <= '0;
        rear_reg  <= '0;
        count_reg <= '0;
        for (int i = 0; i < DEPTH; i++) state_reg[i] <= ST_EMPTY;
      end else begin
        if (accept) rear_reg <= rear_reg + 1'b1;
        if (pop) head_reg <= head_reg + 1'b1;
        count_reg <= count_reg + (DEPTH_W+1)'(accept) - (DEPTH_W+1)'(pop);
        for (int i = 0; i < DEPTH; i++) begin
          if (wb_hit[i] && state_reg[i] == ST_BUSY) state_reg[i] <= ST_READY;
          if (pop && head_reg == DEPTH_W'(i)) state_reg[i] <= ST_EMPTY;
          if (accept && rear_reg == DEPTH_W'(i)) state_reg[i] <= disp_done ? ST_READY : ST_BUSY;
        end
      end
    end
  end

  // Payload storage carries no reset: an entry's fields are only read once its state says so.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (accept) begin
        type_reg[rear_reg]       <= disp_type;
        is_c_reg[rear_reg]       <= disp_is_c;
        rd_reg[rear_reg]         <= disp_rd;
        pc_reg[rear_reg]         <= disp_pc;
        pred_taken_reg[rear_reg] <= disp_pred_taken;
        pred_tgt_reg[rear_reg]   <= disp_pred_target;
        value_reg[rear_reg]      <= disp_value;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_hit[i] && state_reg[i] == ST_BUSY) begin
          value_reg[i] <= wb_sel_value[i];
          addr_reg[i]  <= wb_sel_addr[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport at DEPTH_W=2, NUM_WB=3 with hand-computed expectations.
module tb_rob_multiport;
  localparam int DW = 2;
  localparam int NW = 3;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, disp_valid, disp_ready, disp_is_c, disp_pred_taken, disp_done;
  logic [DW-1:0] disp_tag;
  logic [2:0]    disp_type;
  logic [4:0]    disp_rd;
  logic [31:0]   disp_pc, disp_pred_target, disp_value;
  logic [NW-1:0]    wb_valid;
  logic [NW*DW-1:0] wb_tag;
  logic [NW*32-1:0] wb_value, wb_addr;
  logic [2*DW-1:0]  qry_tag;
  logic [1:0]       qry_ready;
  logic [63:0]      qry_value;
  logic          commit_rf_valid, commit_st_valid, st_busy, commit_br_valid, commit_br_taken;
  logic          flush_out, halt_out;
  logic [4:0]    commit_rd;
  logic [31:0]   commit_value, commit_st_addr, commit_st_data, commit_br_pc, flush_pc;
  logic [DW-1:0] commit_tag;
  logic [1:0]    commit_st_size;
  logic [DW:0]   count_out;

  int n_tests = 0;
  int n_fail  = 0;

  rob_multiport #(.DEPTH_W(DW), .NUM_WB(NW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_tag(disp_tag), .disp_type(disp_type),
    .disp_is_c(disp_is_c), .disp_rd(disp_rd), .disp_pc(disp_pc), .disp_pred_taken(disp_pred_taken),
    .disp_pred_target(disp_pred_target), .disp_done(disp_done), .disp_value(disp_value),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_addr(wb_addr),
    .qry_tag(qry_tag), .qry_ready(qry_ready), .qry_value(qry_value),
    .commit_rf_valid(commit_rf_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_tag(commit_tag), .commit_st_valid(commit_st_valid), .commit_st_size(commit_st_size),
    .commit_st_addr(commit_st_addr), .commit_st_data(commit_st_data), .st_busy(st_busy),
    .commit_br_valid(commit_br_valid), .commit_br_pc(commit_br_pc), .commit_br_taken(commit_br_taken),
    .flush_out(flush_out), .flush_pc(flush_pc), .halt_out(halt_out), .count_out(count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic disp(input logic [2:0] ty, input logic [4:0] rd, input logic [31:0] pc,
                      input logic done, input logic [31:0] val, input logic is_c,
                      input logic pt, input logic [31:0] ptgt);
    disp_valid = 1'b1; disp_type = ty; disp_rd = rd; disp_pc = pc; disp_done = done;
    disp_value = val; disp_is_c = is_c; disp_pred_taken = pt; disp_pred_target = ptgt;
  endtask

  task automatic set_wb(input int k, input logic [DW-1:0] tag, input logic [31:0] val,
                        input logic [31:0] addr);
    wb_valid[k] = 1'b1;
    wb_tag[k*DW +: DW] = tag;
    wb_value[k*32 +: 32] = val;
    wb_addr[k*32 +: 32] = addr;
  endtask

  task automatic clr_wb();
    wb_valid = '0; wb_tag = '0; wb_value = '0; wb_addr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; st_busy = 1'b0; qry_tag = '0;
    disp_valid = 1'b0; disp_type = '0; disp_rd = '0; disp_pc = '0; disp_done = 1'b0;
    disp_value = '0; disp_is_c = 1'b0; disp_pred_taken = 1'b0; disp_pred_target = '0;
    clr_wb();
    tick(); tick();
    check_eq("reset count", 64'(count_out), 64'd0);
    check_eq("reset disp_tag", 64'(disp_tag), 64'd0);
    check_eq("reset rf_valid", 64'(commit_rf_valid), 64'd0);
    check_eq("reset flush", 64'(flush_out), 64'd0);
    check_eq("reset halt", 64'(halt_out), 64'd0);
    rst_in = 1'b1;

    // 1: fill to capacity, then a fifth request is refused
    for (int i = 0; i < 4; i++) begin
      disp(3'd3, 5'(i + 1), 32'(16 * i), 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      tick();
    end
    check_eq("full disp_ready", 64'(disp_ready), 64'd0);
    check_eq("full count", 64'(count_out), 64'd4);
    check_eq("full disp_tag wrapped", 64'(disp_tag), 64'd0);
    tick();
    disp_valid = 1'b0;
    check_eq("5th refused count", 64'(count_out), 64'd4);

    // 2: bypass with ch1 and ch2 on tag 0, lowest channel wins
    set_wb(1, 2'd0, 32'h55, 32'd0);
    set_wb(2, 2'd0, 32'h66, 32'd0);
    qry_tag = {2'd1, 2'd0};
    #1;
    check_eq("qry0 ready", 64'(qry_ready[0]), 64'd1);
    check_eq("qry0 value", 64'(qry_value[31:0]), 64'h55);
    check_eq("qry1 busy not ready", 64'(qry_ready[1]), 64'd0);
    tick();
    clr_wb();
    check_eq("no commit yet", 64'(commit_rf_valid), 64'd0);
    tick();
    check_eq("commit0 valid", 64'(commit_rf_valid), 64'd1);
    check_eq("commit0 value", 64'(commit_value), 64'h55);
    check_eq("commit0 tag", 64'(commit_tag), 64'd0);
    check_eq("commit0 rd", 64'(commit_rd), 64'd1);
    check_eq("count after commit0", 64'(count_out), 64'd3);
    set_wb(0, 2'd1, 32'h11, 32'd0);
    set_wb(1, 2'd2, 32'h22, 32'd0);
    set_wb(2, 2'd3, 32'h33, 32'd0);
    tick();
    clr_wb();
    set_wb(0, 2'd3, 32'h99, 32'd0);
    tick();
    clr_wb();
    check_eq("commit1 tag", 64'(commit_tag), 64'd1);
    check_eq("commit1 value", 64'(commit_value), 64'h11);
    tick();
    check_eq("commit2 value", 64'(commit_value), 64'h22);
    tick();
    check_eq("commit3 value ignores late wb", 64'(commit_value), 64'h33);
    check_eq("drained count", 64'(count_out), 64'd0);
    tick();
    check_eq("rf pulse ends", 64'(commit_rf_valid), 64'd0);

    // 3: branch predicted taken resolves not-taken with a younger entry behind it
    disp(3'd5, 5'd0, 32'h100, 1'b0, 32'd0, 1'b0, 1'b1, 32'h200);
    tick();
    disp(3'd3, 5'd7, 32'h104, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    disp_valid = 1'b0;
    set_wb(0, 2'd0, 32'h0, 32'd0);
    tick();
    clr_wb();
    disp(3'd3, 5'd8, 32'h108, 1'b1, 32'h1, 1'b0, 1'b0, 32'd0);
    tick();
    disp_valid = 1'b0;
    check_eq("flush pulse", 64'(flush_out), 64'd1);
    check_eq("flush_pc fallthrough", 64'(flush_pc), 64'h104);
    check_eq("br valid", 64'(commit_br_valid), 64'd1);
    check_eq("br taken", 64'(commit_br_taken), 64'd0);
    check_eq("br pc", 64'(commit_br_pc), 64'h100);
    check_eq("flush count", 64'(count_out), 64'd0);
    check_eq("flush blocks dispatch", 64'(disp_ready), 64'd0);
    tick();
    check_eq("flush ends", 64'(flush_out), 64'd0);
    check_eq("dispatch reopens", 64'(disp_ready), 64'd1);
    check_eq("rear reset by flush", 64'(disp_tag), 64'd0);

    // 4: store held by st_busy, then a single pulse
    disp(3'd2, 5'd0, 32'h200, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    disp_valid = 1'b0;
    st_busy = 1'b1;
    set_wb(2, 2'd0, 32'hDEADBEEF, 32'h1000);
    tick();
    clr_wb();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("st stall %0d", i), 64'(commit_st_valid), 64'd0);
      check_eq($sformatf("st stall count %0d", i), 64'(count_out), 64'd1);
    end
    st_busy = 1'b0;
    tick();
    check_eq("st valid", 64'(commit_st_valid), 64'd1);
    check_eq("st addr", 64'(commit_st_addr), 64'h1000);
    check_eq("st data", 64'(commit_st_data), 64'hDEADBEEF);
    check_eq("st size", 64'(commit_st_size), 64'd2);
    check_eq("st popped", 64'(count_out), 64'd0);
    tick();
    check_eq("st single pulse", 64'(commit_st_valid), 64'd0);

    // JALR predicted correctly: link value committed, no flush
    disp(3'd4, 5'd5, 32'h40, 1'b0, 32'd0, 1'b1, 1'b0, 32'h80);
    tick();
    disp_valid = 1'b0;
    set_wb(0, 2'd1, 32'h80, 32'd0);
    tick();
    clr_wb();
    tick();
    check_eq("jalr rf valid", 64'(commit_rf_valid), 64'd1);
    check_eq("jalr link", 64'(commit_value), 64'h42);
    check_eq("jalr rd", 64'(commit_rd), 64'd5);
    check_eq("jalr tag", 64'(commit_tag), 64'd1);
    check_eq("jalr no flush", 64'(flush_out), 64'd0);

    // 5: nine back-to-back ready dispatches, commits wrap tags 2,3,0,1,...
    for (int i = 0; i < 9; i++) begin
      disp(3'd3, 5'(i + 1), 32'd0, 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 32'd0);
      tick();
      if (i > 0) begin
        check_eq($sformatf("wrap tag %0d", i), 64'(commit_tag), 64'((2 + i - 1) % 4));
        check_eq($sformatf("wrap value %0d", i), 64'(commit_value), 64'h100 + 64'(i - 1));
      end
      check_eq($sformatf("wrap count %0d", i), 64'(count_out), 64'd1);
    end
    disp_valid = 1'b0;
    tick();
    check_eq("wrap last tag", 64'(commit_tag), 64'd2);
    check_eq("wrap last value", 64'(commit_value), 64'h108);
    check_eq("wrap empty", 64'(count_out), 64'd0);
    for (int i = 0; i < 4; i++) begin
      disp(3'd3, 5'd9, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      tick();
    end
    check_eq("refill count", 64'(count_out), 64'd4);
    disp(3'd3, 5'd10, 32'd0, 1'b1, 32'h77, 1'b0, 1'b0, 32'd0);
    set_wb(0, 2'd3, 32'hA3, 32'd0);
    tick();
    clr_wb();
    check_eq("full wb no accept", 64'(count_out), 64'd4);
    tick();
    check_eq("commit frees no slot early", 64'(count_out), 64'd3);
    check_eq("full commit tag", 64'(commit_tag), 64'd3);
    check_eq("full commit value", 64'(commit_value), 64'hA3);
    tick();
    disp_valid = 1'b0;
    check_eq("accept after free", 64'(count_out), 64'd4);

    // 6: asynchronous reset mid-operation
    set_wb(1, 2'd0, 32'hB0, 32'd0);
    tick();
    clr_wb();
    tick();
    check_eq("pre-reset rf valid", 64'(commit_rf_valid), 64'd1);
    check_eq("pre-reset count", 64'(count_out), 64'd3);
    #2;
    rst_in = 1'b0;
    #1;
    check_eq("async count", 64'(count_out), 64'd0);
    check_eq("async rf valid", 64'(commit_rf_valid), 64'd0);
    check_eq("async value", 64'(commit_value), 64'd0);
    check_eq("async disp_tag", 64'(disp_tag), 64'd0);
    tick();
    rst_in = 1'b1;

    // rdy_in low freezes dispatch; EXIT halts further commits
    rdy_in = 1'b0;
    disp(3'd6, 5'd0, 32'h300, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();
    check_eq("rdy low no dispatch", 64'(count_out), 64'd0);
    rdy_in = 1'b1;
    tick();
    check_eq("exit dispatched", 64'(count_out), 64'd1);
    disp(3'd3, 5'd3, 32'h304, 1'b1, 32'h5, 1'b0, 1'b0, 32'd0);
    tick();
    disp_valid = 1'b0;
    check_eq("halt set", 64'(halt_out), 64'd1);
    check_eq("exit popped, reg in", 64'(count_out), 64'd1);
    tick();
    tick();
    check_eq("halted no commit", 64'(commit_rf_valid), 64'd0);
    check_eq("halted count holds", 64'(count_out), 64'd1);
    check_eq("halt sticky", 64'(halt_out), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
